// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing datapath blocks.
package sc_pkg;
  localparam int SC_WIDTH       = 8;
  localparam int SC_LFSR_PERIOD = 255;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } sc_dec_state_t;
endpackage

// File: rtl/sc_window_counter.sv
// Window counter: counts accepted bits and the 1s among them, and flags the last
// bit of a window. Both counters fold back to zero when the last bit is accepted.
module sc_window_counter
  import sc_pkg::*;
#(
  parameter int WIDTH  = SC_WIDTH,
  parameter int WINDOW = SC_LFSR_PERIOD
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] ones_cnt,
  output logic             last
);

  localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(WINDOW - 1);

  logic [WIDTH-1:0] bit_cnt_r;
  logic [WIDTH-1:0] ones_cnt_r;

  // Bit and ones counters; the window end restarts both for the next window.
  always_ff @(posedge clk) begin
    if (clear) begin
      bit_cnt_r  <= '0;
      ones_cnt_r <= '0;
    end else if (en && last) begin
      bit_cnt_r  <= '0;
      ones_cnt_r <= '0;
    end else if (en) begin
      bit_cnt_r  <= bit_cnt_r + WIDTH'(1'b1);
      ones_cnt_r <= ones_cnt_r + {{(WIDTH-1){1'b0}}, bit_in};
    end else begin
      bit_cnt_r  <= bit_cnt_r;
      ones_cnt_r <= ones_cnt_r;
    end
  end

  assign last     = (bit_cnt_r == LAST_IDX);
  assign ones_cnt = ones_cnt_r;

endmodule

// File: rtl/sc_bitstream_decoder.sv
// Stochastic-to-binary converter: counts 1s over a fixed window and hands the count
// out through a valid/ready result register that is independent of the accumulator.
module sc_bitstream_decoder
  import sc_pkg::*;
#(
  parameter int WIDTH      = SC_WIDTH,
  parameter int WINDOW     = SC_LFSR_PERIOD,
  parameter int CONTINUOUS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             busy,
  output logic             overrun
);

  sc_dec_state_t    state_r;
  sc_dec_state_t    state_nxt_s;
  logic [WIDTH-1:0] ones_cnt_s;
  logic             last_s;
  logic             accept_s;
  logic             win_done_s;
  logic [WIDTH-1:0] final_cnt_s;
  logic [WIDTH-1:0] result_r;
  logic             result_valid_r;
  logic             overrun_r;

  assign accept_s    = (state_r == ACCUM) && bit_valid;
  assign win_done_s  = accept_s && last_s;
  // The closing bit is still in flight, so it is added here rather than in the counter.
  assign final_cnt_s = ones_cnt_s + {{(WIDTH-1){1'b0}}, bit_in};

  sc_window_counter #(
    .WIDTH  (WIDTH),
    .WINDOW (WINDOW)
  ) u_window_counter (
    .clk      (clk),
    .clear    (rst_n),
    .en       (accept_s),
    .bit_in   (bit_in),
    .ones_cnt (ones_cnt_s),
    .last     (last_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = ACCUM;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCUM: begin
        if (win_done_s && (CONTINUOUS == 0)) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = ACCUM;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Result register, handshake and sticky overrun; a waiting result is never overwritten.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      result_r       <= '0;
      result_valid_r <= 1'b0;
      overrun_r      <= 1'b0;
    end else if (win_done_s && (!result_valid_r || result_ready)) begin
      result_r       <= final_cnt_s;
      result_valid_r <= 1'b1;
      overrun_r      <= overrun_r;
    end else if (win_done_s) begin
      result_r       <= result_r;
      result_valid_r <= result_valid_r;
      overrun_r      <= 1'b1;
    end else if (result_valid_r && result_ready) begin
      result_r       <= result_r;
      result_valid_r <= 1'b0;
      overrun_r      <= overrun_r;
    end else begin
      result_r       <= result_r;
      result_valid_r <= result_valid_r;
      overrun_r      <= overrun_r;
    end
  end

  assign result       = result_r;
  assign result_valid = result_valid_r;
  assign overrun      = overrun_r;
  assign busy         = (state_r == ACCUM);

endmodule

// File: tb/tb_sc_bitstream_decoder.sv
// Scoreboard bench for sc_bitstream_decoder: a window-level model queues expected
// counts; a negedge monitor compares every presented result and pops on transfer.
module tb_sc_bitstream_decoder;
  localparam int WIDTH  = 8;
  localparam int WINDOW = 255;
  localparam bit CONT   = 1'b1;

  logic             clk = 1'b0;
  logic             rst_n, start, bit_valid, bit_in, result_ready;
  logic [WIDTH-1:0] result;
  logic             result_valid, busy, overrun;

  int checks   = 0;
  int failures = 0;

  // Model: bits of the open window, expected results in presentation order.
  int exp_q[$];
  bit m_bits[$];
  bit m_busy, m_pending, m_overrun;

  always #5 clk = ~clk;

  sc_bitstream_decoder #(
    .WIDTH      (WIDTH),
    .WINDOW     (WINDOW),
    .CONTINUOUS (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .bit_valid    (bit_valid),
    .bit_in       (bit_in),
    .result_ready (result_ready),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: whatever is presented must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n === 1'b0 && result_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: actual=%0d expected=none at %0t", result, $time);
      end else begin
        chk("result", {24'd0, result}, exp_q[0]);
        if (result_ready === 1'b1) void'(exp_q.pop_front());
      end
    end
  end

  task automatic do_reset(input int n);
    rst_n = 1'b1; start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; result_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
    exp_q.delete(); m_bits.delete();
    m_busy = 1'b0; m_pending = 1'b0; m_overrun = 1'b0;
    chk("rst_result", {24'd0, result}, 32'd0);
    chk("rst_valid", {31'd0, result_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    rst_n = 1'b0;
  endtask

  // One clock of stimulus; the model predicts the state after the edge.
  task automatic step(input logic s, input logic bv, input logic b, input logic rdy);
    bit done, pend_n, busy_n;
    int sum;
    done = 1'b0; sum = 0;
    start = s; bit_valid = bv; bit_in = b; result_ready = rdy;
    busy_n = m_busy;
    if (!m_busy) begin
      if (s) busy_n = 1'b1;
    end else if (bv) begin
      m_bits.push_back(b);
      if (m_bits.size() == WINDOW) begin
        foreach (m_bits[i]) sum += int'(m_bits[i]);
        m_bits.delete();
        done = 1'b1;
      end
    end
    pend_n = m_pending && !rdy;
    if (done) begin
      if (!m_pending || rdy) begin
        exp_q.push_back(sum);
        pend_n = 1'b1;
      end else begin
        m_overrun = 1'b1;
      end
      if (!CONT) busy_n = 1'b0;
    end
    @(posedge clk); #1;
    m_busy = busy_n; m_pending = pend_n;
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("result_valid", {31'd0, result_valid}, {31'd0, m_pending});
    chk("overrun", {31'd0, overrun}, {31'd0, m_overrun});
  endtask

  initial begin
    logic [7:0] lfsr;
    rst_n = 1'b1; start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; result_ready = 1'b0;

    // Reset, then idle with no start: nothing must happen.
    do_reset(2);
    for (int i = 0; i < 10; i++) step(1'b0, 1'(i % 2), 1'b1, 1'b1);

    // Start cycle bit is ignored, then a window of all 1s.
    step(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < WINDOW; i++) step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Window of 0s with random valid gaps (start ignored while accumulating).
    for (int i = 0; i < WINDOW; ) begin
      logic v;
      v = 1'($urandom_range(0, 2) != 0);
      step(1'($urandom_range(0, 1)), v, 1'b0, 1'b1);
      if (v) i++;
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Full-period LFSR against comparator threshold 128.
    lfsr = 8'd1;
    for (int i = 0; i < WINDOW; i++) begin
      step(1'b0, 1'b1, (lfsr <= 8'd128), 1'b1);
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Two windows with no consumer: second count dropped, overrun sticks.
    for (int i = 0; i < WINDOW; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < WINDOW; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Abort at bit 100, then a clean window from a fresh start.
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b1, 1'b1);
    do_reset(1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < WINDOW; i++) step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Random bits, valid gaps and back-pressure over several windows.
    for (int i = 0; i < 4 * WINDOW + 200; i++)
      step(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("drain", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
